// File: rtl/mips_decode_execute_unit.sv
// mips_decode_execute_unit: MIPS main/ALU-control decode, ID/EX register and 32-bit ALU.
// Unknown encodings and Flush both load the all-zero NOP, identical to the reset state.
module mips_decode_execute_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flush,
  input  logic [31:0] InstructionD,
  input  logic [31:0] ReadData1D,
  input  logic [31:0] ReadData2D,
  output logic [31:0] ALUResultE,
  output logic        ZeroE,
  output logic [31:0] ReadData2E,
  output logic [4:0]  WriteRegE,
  output logic        RegWriteE,
  output logic        MemReadE,
  output logic        MemWriteE,
  output logic        MemToRegE,
  output logic [1:0]  MemTypeE,
  output logic [1:0]  BranchTypeE
);
  logic [5:0]  op, fn;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic [4:0]  dst;
  logic        unused_rs;
  logic        valid, use_imm, zext, rdst, rw, mr, mw, m2r, keep;
  logic [3:0]  ctrl;
  logic [1:0]  mt, bt;
  logic [31:0] a_d, a_q, b_d, b_q, rd2_d, rd2_q;
  logic [4:0]  sh_d, sh_q, wr_d, wr_q, sa;
  logic [3:0]  ctrl_d, ctrl_q;
  logic        rw_d, rw_q, mr_d, mr_q, mw_d, mw_q, m2r_d, m2r_q;
  logic [1:0]  mt_d, mt_q, bt_d, bt_q;
  assign op        = InstructionD[31:26];
  assign fn        = InstructionD[5:0];
  assign imm       = InstructionD[15:0];
  assign unused_rs = ^InstructionD[25:21];
  always_comb begin
    valid   = 1'b1;
    ctrl    = 4'd2;
    use_imm = 1'b1;
    zext    = 1'b0;
    rdst    = 1'b0;
    rw      = 1'b1;
    mr      = 1'b0;
    mw      = 1'b0;
    m2r     = 1'b0;
    mt      = 2'd0;
    bt      = 2'd0;
    case (op)
      6'h00: begin
        use_imm = 1'b0;
        rdst    = 1'b1;
        case (fn)
          6'h20, 6'h21: ctrl = 4'd2;
          6'h22, 6'h23: ctrl = 4'd6;
          6'h24: ctrl = 4'd0;
          6'h25: ctrl = 4'd1;
          6'h26: ctrl = 4'd3;
          6'h27: ctrl = 4'd4;
          6'h2A: ctrl = 4'd7;
          6'h2B: ctrl = 4'd8;
          6'h00: ctrl = 4'd5;
          6'h02: ctrl = 4'd9;
          6'h03: ctrl = 4'd10;
          6'h04: ctrl = 4'd13;
          6'h06: ctrl = 4'd14;
          6'h07: ctrl = 4'd15;
          default: valid = 1'b0;
        endcase
      end
      6'h1C: begin
        use_imm = 1'b0;
        rdst    = 1'b1;
        ctrl    = 4'd11;
        valid   = fn == 6'h02;
      end
      6'h08, 6'h09: ctrl = 4'd2;
      6'h0A: ctrl = 4'd7;
      6'h0B: ctrl = 4'd8;
      6'h0C: begin ctrl = 4'd0; zext = 1'b1; end
      6'h0D: begin ctrl = 4'd1; zext = 1'b1; end
      6'h0E: begin ctrl = 4'd3; zext = 1'b1; end
      6'h0F: begin ctrl = 4'd12; zext = 1'b1; end
      6'h20, 6'h21, 6'h23: begin mr = 1'b1; m2r = 1'b1; mt = op[1:0]; end
      6'h28, 6'h29, 6'h2B: begin rw = 1'b0; mw = 1'b1; mt = op[1:0]; end
      6'h04, 6'h05: begin use_imm = 1'b0; ctrl = 4'd6; rw = 1'b0; bt = op[0] ? 2'd2 : 2'd1; end
      6'h02: begin use_imm = 1'b0; rw = 1'b0; bt = 2'd3; end
      default: valid = 1'b0;
    endcase
  end
  assign imm_ext = zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
  assign dst     = rdst ? InstructionD[15:11] : InstructionD[20:16];
  always_comb begin
    keep   = valid & ~Flush;
    a_d    = keep ? ReadData1D : '0;
    b_d    = keep ? (use_imm ? imm_ext : ReadData2D) : '0;
    rd2_d  = keep ? ReadData2D : '0;
    sh_d   = keep ? InstructionD[10:6] : '0;
    ctrl_d = keep ? ctrl : '0;
    wr_d   = keep ? dst : '0;
    rw_d   = keep & rw & (dst != 5'd0);
    mr_d   = keep & mr;
    mw_d   = keep & mw;
    m2r_d  = keep & m2r;
    mt_d   = keep ? mt : '0;
    bt_d   = keep ? bt : '0;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      rd2_q  <= '0;
      sh_q   <= '0;
      ctrl_q <= '0;
      wr_q   <= '0;
      rw_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      mt_q   <= '0;
      bt_q   <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      rd2_q  <= rd2_d;
      sh_q   <= sh_d;
      ctrl_q <= ctrl_d;
      wr_q   <= wr_d;
      rw_q   <= rw_d;
      mr_q   <= mr_d;
      mw_q   <= mw_d;
      m2r_q  <= m2r_d;
      mt_q   <= mt_d;
      bt_q   <= bt_d;
    end
  end
  // Variable shifts take their amount from rs; fixed shifts from shamt.
  assign sa = ctrl_q >= 4'd13 ? a_q[4:0] : sh_q;
  always_comb begin
    case (ctrl_q)
      4'd0:    ALUResultE = a_q & b_q;
      4'd1:    ALUResultE = a_q | b_q;
      4'd2:    ALUResultE = a_q + b_q;
      4'd3:    ALUResultE = a_q ^ b_q;
      4'd4:    ALUResultE = ~(a_q | b_q);
      4'd6:    ALUResultE = a_q - b_q;
      4'd7:    ALUResultE = {31'h0, $signed(a_q) < $signed(b_q)};
      4'd8:    ALUResultE = {31'h0, a_q < b_q};
      4'd9:    ALUResultE = b_q >> sa;
      4'd11:   ALUResultE = a_q * b_q;
      4'd12:   ALUResultE = b_q << 16;
      4'd5, 4'd13: ALUResultE = b_q << sa;
      4'd14:   ALUResultE = b_q >> sa;
      default: ALUResultE = $signed(b_q) >>> sa;
    endcase
  end
  assign ZeroE       = ALUResultE == 32'h0;
  assign ReadData2E  = rd2_q;
  assign WriteRegE   = wr_q;
  assign RegWriteE   = rw_q;
  assign MemReadE    = mr_q;
  assign MemWriteE   = mw_q;
  assign MemToRegE   = m2r_q;
  assign MemTypeE    = mt_q;
  assign BranchTypeE = bt_q;
endmodule

// File: tb/tb_mips_decode_execute_unit.sv
// tb_mips_decode_execute_unit: directed scoreboard bench for the ID/EX slice.
module tb_mips_decode_execute_unit;
  logic        Clk = 1'b0, Reset = 1'b0, Flush = 1'b0;
  logic [31:0] InstructionD = '0, ReadData1D = '0, ReadData2D = '0;
  logic [31:0] ALUResultE, ReadData2E;
  logic        ZeroE, RegWriteE, MemReadE, MemWriteE, MemToRegE;
  logic [4:0]  WriteRegE;
  logic [1:0]  MemTypeE, BranchTypeE;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r;
    logic [1:0]  mt, bt;
    logic [31:0] rd2;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;

  mips_decode_execute_unit dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InstructionD(InstructionD),
    .ReadData1D(ReadData1D), .ReadData2D(ReadData2D), .ALUResultE(ALUResultE),
    .ZeroE(ZeroE), .ReadData2E(ReadData2E), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .MemToRegE(MemToRegE), .MemTypeE(MemTypeE), .BranchTypeE(BranchTypeE)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [31:0] alu, input logic [4:0] wr,
                              input logic rw, mr, mw, m2r, input logic [1:0] mt, bt,
                              input logic [31:0] rd2, input logic chk);
    exp_t e;
    e.alu = alu; e.zero = (alu == 32'h0); e.wr = wr;
    e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r;
    e.mt = mt; e.bt = bt; e.rd2 = rd2; e.chk = chk;
    return e;
  endfunction

  task automatic cmp(input string n, input string f, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", n, f, obs, expv);
    end
  endtask

  task automatic compare(input string n);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", n);
      return;
    end
    e = sb.pop_front();
    cmp(n, "alu", ALUResultE, e.alu);
    cmp(n, "zero", 32'(ZeroE), 32'(e.zero));
    cmp(n, "regwrite", 32'(RegWriteE), 32'(e.rw));
    cmp(n, "memread", 32'(MemReadE), 32'(e.mr));
    cmp(n, "memwrite", 32'(MemWriteE), 32'(e.mw));
    cmp(n, "memtoreg", 32'(MemToRegE), 32'(e.m2r));
    cmp(n, "memtype", 32'(MemTypeE), 32'(e.mt));
    cmp(n, "branchtype", 32'(BranchTypeE), 32'(e.bt));
    if (e.chk) begin
      cmp(n, "writereg", 32'(WriteRegE), 32'(e.wr));
      cmp(n, "rd2", ReadData2E, e.rd2);
    end
  endtask

  task automatic step(input logic [31:0] ins, a, b, input logic fl, input exp_t e, input string n);
    @(negedge Clk);
    InstructionD = ins;
    ReadData1D   = a;
    ReadData2D   = b;
    Flush        = fl;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    compare(n);
  endtask

  initial begin
    @(negedge Clk);
    InstructionD = 32'h00221820; ReadData1D = 5; ReadData2D = 7;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge Clk); #1;
    compare("reset");
    @(negedge Clk);
    Reset = 1'b1;
    step(32'h00221820, 5, 7, 0, mk(12, 3, 1, 0, 0, 0, 0, 0, 7, 1), "add");
    @(negedge Clk);
    InstructionD = r(1, 2, 3, 0, 6'h22); ReadData1D = 3; ReadData2D = 5;
    Reset = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    compare("async_reset");
    @(negedge Clk);
    Reset = 1'b1;
    step(r(1, 2, 3, 0, 6'h22), 3, 5, 0, mk(32'hFFFFFFFE, 3, 1, 0, 0, 0, 0, 0, 5, 1), "sub");
    step(r(1, 2, 3, 0, 6'h23), 3, 5, 0, mk(32'hFFFFFFFE, 3, 1, 0, 0, 0, 0, 0, 5, 1), "subu");
    step(r(1, 2, 3, 0, 6'h21), 5, 7, 0, mk(12, 3, 1, 0, 0, 0, 0, 0, 7, 1), "addu");
    step(r(1, 2, 3, 0, 6'h2A), 3, 5, 0, mk(1, 3, 1, 0, 0, 0, 0, 0, 5, 1), "slt");
    step(r(1, 2, 3, 0, 6'h2B), 32'hFFFFFFFF, 1, 0, mk(0, 3, 1, 0, 0, 0, 0, 0, 1, 1), "sltu");
    step(r(1, 2, 3, 0, 6'h24), 32'hF0F0, 32'hFF00, 0, mk(32'hF000, 3, 1, 0, 0, 0, 0, 0, 32'hFF00, 1), "and");
    step(r(1, 2, 3, 0, 6'h25), 32'hF0F0, 32'hFF00, 0, mk(32'hFFF0, 3, 1, 0, 0, 0, 0, 0, 32'hFF00, 1), "or");
    step(r(1, 2, 3, 0, 6'h26), 32'hF0F0, 32'hFF00, 0, mk(32'h0FF0, 3, 1, 0, 0, 0, 0, 0, 32'hFF00, 1), "xor");
    step(r(1, 2, 3, 0, 6'h27), 32'hF0F0, 32'hFF00, 0, mk(32'hFFFF000F, 3, 1, 0, 0, 0, 0, 0, 32'hFF00, 1), "nor");
    step(r(0, 1, 2, 4, 6'h03), 0, 32'h80000000, 0, mk(32'hF8000000, 2, 1, 0, 0, 0, 0, 0, 32'h80000000, 1), "sra");
    step(r(0, 1, 2, 4, 6'h02), 0, 32'h80000000, 0, mk(32'h08000000, 2, 1, 0, 0, 0, 0, 0, 32'h80000000, 1), "srl");
    step(r(0, 1, 2, 8, 6'h00), 0, 1, 0, mk(32'h100, 2, 1, 0, 0, 0, 0, 0, 1, 1), "sll");
    step(r(1, 2, 3, 0, 6'h04), 4, 3, 0, mk(32'h30, 3, 1, 0, 0, 0, 0, 0, 3, 1), "sllv");
    step(r(1, 2, 3, 0, 6'h06), 8, 32'h80000000, 0, mk(32'h00800000, 3, 1, 0, 0, 0, 0, 0, 32'h80000000, 1), "srlv");
    step(r(1, 2, 3, 0, 6'h07), 8, 32'h80000000, 0, mk(32'hFF800000, 3, 1, 0, 0, 0, 0, 0, 32'h80000000, 1), "srav");
    step(i(6'h0D, 1, 2, 16'h8000), 0, 32'h55, 0, mk(32'h8000, 2, 1, 0, 0, 0, 0, 0, 32'h55, 1), "ori");
    step(i(6'h08, 1, 2, 16'hFFFF), 1, 0, 0, mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 1), "addi");
    step(i(6'h0A, 1, 2, 16'h0001), 32'hFFFFFFFF, 0, 0, mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 1), "slti");
    step(i(6'h0B, 1, 2, 16'hFFFF), 5, 0, 0, mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 1), "sltiu");
    step(i(6'h0C, 1, 2, 16'hFFFF), 32'hFFFF1234, 0, 0, mk(32'h1234, 2, 1, 0, 0, 0, 0, 0, 0, 1), "andi");
    step(i(6'h0E, 1, 2, 16'h8000), 32'hFFFFFFFF, 0, 0, mk(32'hFFFF7FFF, 2, 1, 0, 0, 0, 0, 0, 0, 1), "xori");
    step(i(6'h0F, 0, 2, 16'h1234), 0, 0, 0, mk(32'h12340000, 2, 1, 0, 0, 0, 0, 0, 0, 1), "lui");
    step(i(6'h23, 1, 4, 16'hFFFC), 32'h100, 0, 0, mk(32'hFC, 4, 1, 1, 0, 1, 2'b11, 0, 0, 1), "lw");
    step(i(6'h21, 1, 5, 16'h0002), 32'h10, 0, 0, mk(32'h12, 5, 1, 1, 0, 1, 2'b01, 0, 0, 1), "lh");
    step(i(6'h20, 1, 5, 16'h0001), 32'h10, 0, 0, mk(32'h11, 5, 1, 1, 0, 1, 2'b00, 0, 0, 1), "lb");
    step(i(6'h28, 1, 4, 16'h0003), 32'h100, 32'hAB, 0, mk(32'h103, 4, 0, 0, 1, 0, 2'b00, 0, 32'hAB, 1), "sb");
    step(i(6'h29, 1, 4, 16'h0002), 32'h100, 32'hAB, 0, mk(32'h102, 4, 0, 0, 1, 0, 2'b01, 0, 32'hAB, 1), "sh");
    step(i(6'h2B, 1, 5, 16'h0000), 32'h20, 32'hCAFE, 0, mk(32'h20, 5, 0, 0, 1, 0, 2'b11, 0, 32'hCAFE, 1), "sw");
    step(i(6'h04, 1, 2, 16'h0010), 9, 9, 0, mk(0, 2, 0, 0, 0, 0, 0, 2'b01, 9, 1), "beq");
    step(i(6'h05, 1, 2, 16'h0010), 9, 8, 0, mk(1, 2, 0, 0, 0, 0, 0, 2'b10, 8, 1), "bne");
    step(32'h08000010, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0), "j");
    step({6'h1C, 5'd1, 5'd2, 5'd5, 5'd0, 6'h02}, 32'hFFFFFFFD, 4, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "flush");
    step({6'h1C, 5'd1, 5'd2, 5'd5, 5'd0, 6'h02}, 32'hFFFFFFFD, 4, 0, mk(32'hFFFFFFF4, 5, 1, 0, 0, 0, 0, 0, 4, 1), "mul");
    step(r(1, 2, 0, 0, 6'h20), 5, 7, 0, mk(12, 0, 0, 0, 0, 0, 0, 0, 7, 1), "add_r0");
    step(32'hFC000000, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bad_opcode");
    step(r(0, 0, 3, 0, 6'h3F), 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bad_funct");
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
